vec_cmd_issuer: RTL and testbench
=================================

VEC_CMD_ISSUER -- requirements
Module: vec_cmd_issuer

Interface
REQ-001 Parameter els_p, default 8, number of vector registers; addr width = BSG_SAFE_CLOG2(els_p).
REQ-002 Parameter vlen_p, default 8, elements per vector.
REQ-003 Parameter vdw_p, default 8, bits per element; data width DW = vlen_p*vdw_p.
REQ-004 Parameter cmd_els_p, default 4, command queue depth (power of two, >=2).
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 cmd_v_i  in  1 / cmd_ready_o  out  1  command enqueue handshake; enqueue when both high.
REQ-008 cmd_op_i  in  4  opcode; cmd_addrA_i, cmd_addrB_i, cmd_addrC_i, cmd_addrD_i  in  addr width each  operand/destination registers.
REQ-009 cmd_scalar_i  in  vdw_p  scalar operand; cmd_w_data_i  in  DW  write payload.
REQ-010 op_o, addrA_o, addrB_o, addrC_o, addrD_o, scalar_o, w_data_o  out  same widths  command presented to the accelerator.
REQ-011 v_o  out  1  command valid to accelerator; ready_i  in  1  accelerator idle/ready.
REQ-012 done_i  in  1  accelerator done; r_data_i  in  DW  accelerator read data; rv_i  in  1  accelerator result valid; yumi_o  out  1  result consume to accelerator.
REQ-013 res_v_o  out  1 / res_data_o  out  DW / res_yumi_i  in  1  read-result output to consumer.
REQ-014 busy_o  out  1  high whenever queue non-empty or FSM not IDLE.

Function
REQ-015 Queue SHALL be FIFO-ordered; enqueued entry visible at head no earlier than the next cycle.
REQ-016 cmd_ready_o SHALL equal !full; no enqueue while full, even if a dequeue occurs the same cycle.
REQ-017 FSM states SHALL be IDLE, ISSUE, EXEC, RESULT.
REQ-018 IDLE: queue non-empty -> ISSUE next cycle; else stay.
REQ-019 ISSUE: v_o=1; on v_o & ready_i -> EXEC; v_o SHALL stay high until accepted.
REQ-020 EXEC: v_o=0; on done_i: op==4'b1000 (read) -> RESULT, any other op -> IDLE with head dequeued.
REQ-021 RESULT: res_v_o = rv_i; res_data_o = r_data_i; yumi_o = res_v_o & res_yumi_i; on yumi_o -> IDLE with head dequeued.
REQ-022 op_o, addr*_o, scalar_o, w_data_o SHALL be driven from the queue head and remain stable from ISSUE entry until the dequeue cycle.
REQ-023 Head entry SHALL dequeue only on command completion, never on issue acceptance.
REQ-024 rv_i/done_i outside EXEC/RESULT SHALL be ignored; yumi_o SHALL be 0 outside RESULT.
REQ-025 Minimum enqueue-to-v_o latency: 2 cycles (enqueue edge, IDLE->ISSUE edge).
REQ-026 Back-to-back: after completion, the next queued command SHALL reach ISSUE exactly 1 cycle after returning to IDLE.
REQ-027 Read/write pointers SHALL wrap modulo cmd_els_p; an occupancy counter of width clog2(cmd_els_p)+1 SHALL define full/empty.

Reset
REQ-028 While reset_i high on an edge: FSM->IDLE, queue emptied, pointers and count to 0.
REQ-029 Post-reset outputs: v_o=0, yumi_o=0, res_v_o=0, busy_o=0, cmd_ready_o=1; data outputs unspecified when not valid.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight commands; accelerator is reset by the same reset_i.

Structure
REQ-031 Shared package vec_pkg SHALL hold the 4-bit opcode enum (ADD 0000, SUB 0001, MUL 0010, ADDS 0100, SUBS 0101, MULS 0110, READ 1000, WRITE 1001, MMUL 1111) and the packed command struct (op, addrA-D, scalar, w_data).
REQ-032 Queue SHALL be one sub-module vec_cmd_fifo (1r1w, registered storage, full/empty outputs); FSM lives in vec_cmd_issuer.

Verification
REQ-033 Single ADD: enqueue op=0000,A=1,B=2,D=3; ready_i=1 -> v_o at cycle 2, EXEC; done_i pulse -> IDLE, busy_o=0 next cycle, res_v_o never high.
REQ-034 Read: op=1000,A=5; rv_i=1, r_data_i=64'hDEADBEEF_01234567, res_yumi_i held 0 for 3 cycles -> res_v_o high and stable, yumi_o=0; res_yumi_i=1 -> yumi_o=1 one cycle, IDLE.
REQ-035 Full: enqueue 4 commands with ready_i=0 -> cmd_ready_o=0 after 4th; 5th cmd_v_i not accepted; queue order preserved on drain.
REQ-036 Stability: ready_i=0 for 5 cycles in ISSUE -> v_o and all operand outputs unchanged every cycle.
REQ-037 Reset in EXEC with 2 queued -> next cycle v_o=0, busy_o=0, cmd_ready_o=1; subsequent done_i ignored.
REQ-038 Back-to-back WRITE then MUL -> second v_o exactly 1 cycle after first completion, pointers wrap correctly after 5+ commands.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector command issuer: opcodes, FSM states,
// the command record layout and a width helper.
// Latency: n/a (types only). Backpressure: n/a.
package vec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_MUL   = 4'b0010,
    OP_ADDS  = 4'b0100,
    OP_SUBS  = 4'b0101,
    OP_MULS  = 4'b0110,
    OP_READ  = 4'b1000,
    OP_WRITE = 4'b1001,
    OP_MMUL  = 4'b1111
  } vec_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC,
    ST_RESULT
  } vec_state_e;

  // Address width that stays >= 1 even for a single-register file.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Default geometry: 8 registers, 8 elements of 8 bits.
  localparam int VEC_AW  = 3;
  localparam int VEC_VDW = 8;
  localparam int VEC_DW  = 64;

  // Field order here matches the flat packing used by the issuer's queue.
  typedef struct packed {
    logic [3:0]         op;
    logic [VEC_AW-1:0]  addrA;
    logic [VEC_AW-1:0]  addrB;
    logic [VEC_AW-1:0]  addrC;
    logic [VEC_AW-1:0]  addrD;
    logic [VEC_VDW-1:0] scalar;
    logic [VEC_DW-1:0]  w_data;
  } vec_cmd_t;

endpackage

// File: rtl/vec_cmd_fifo.sv
// Command queue: 1r1w FIFO with registered storage, head shown combinationally.
// Latency: a written entry is visible at data_o the cycle after the write.
// Backpressure: ready_o = !full_o; writes while full are dropped even if a read occurs.
// Ports: clk_i/reset_i; v_i/data_i/ready_o write side; yumi_i/data_o read side;
//        full_o/empty_o status.
module vec_cmd_fifo
  import vec_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_count;

  logic w_enq;
  logic w_deq;

  assign full_o  = (r_count == cnt_w_lp'(els_p));
  assign empty_o = (r_count == '0);
  assign ready_o = ~full_o;
  assign w_enq   = v_i & ~full_o;
  assign w_deq   = yumi_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/vec_cmd_issuer.sv
// Queues vector commands and issues them one at a time to the accelerator.
// Latency: enqueue to v_o is 2 cycles; next queued command issues 1 cycle after IDLE.
// Backpressure: cmd_ready_o drops when queue full; v_o held until ready_i; result held until res_yumi_i.
// Ports: cmd_* enqueue side; op_o/addr*_o/scalar_o/w_data_o/v_o/ready_i issue side;
//        done_i/rv_i/r_data_i/yumi_o accelerator return; res_* consumer side; busy_o.
module vec_cmd_issuer
  import vec_pkg::*;
#(
  parameter int els_p     = 8,
  parameter int vlen_p    = 8,
  parameter int vdw_p     = 8,
  parameter int cmd_els_p = 4,
  localparam int aw_lp    = safe_clog2(els_p),
  localparam int dw_lp    = vlen_p * vdw_p
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_v_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [aw_lp-1:0] cmd_addrA_i,
  input  logic [aw_lp-1:0] cmd_addrB_i,
  input  logic [aw_lp-1:0] cmd_addrC_i,
  input  logic [aw_lp-1:0] cmd_addrD_i,
  input  logic [vdw_p-1:0] cmd_scalar_i,
  input  logic [dw_lp-1:0] cmd_w_data_i,
  output logic [3:0]       op_o,
  output logic [aw_lp-1:0] addrA_o,
  output logic [aw_lp-1:0] addrB_o,
  output logic [aw_lp-1:0] addrC_o,
  output logic [aw_lp-1:0] addrD_o,
  output logic [vdw_p-1:0] scalar_o,
  output logic [dw_lp-1:0] w_data_o,
  output logic             v_o,
  input  logic             ready_i,
  input  logic             done_i,
  input  logic [dw_lp-1:0] r_data_i,
  input  logic             rv_i,
  output logic             yumi_o,
  output logic             res_v_o,
  output logic [dw_lp-1:0] res_data_o,
  input  logic             res_yumi_i,
  output logic             busy_o
);

  localparam int cmd_w_lp = 4 + 4 * aw_lp + vdw_p + dw_lp;

  vec_state_e          r_state;
  logic                r_v;
  logic [cmd_w_lp-1:0] w_cmd_in;
  logic [cmd_w_lp-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_deq;
  logic                w_is_read;
  logic                w_res_v;
  logic                w_yumi;

  assign w_cmd_in = {cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
                     cmd_addrD_i, cmd_scalar_i, cmd_w_data_i};

  vec_cmd_fifo #(
    .width_p (cmd_w_lp),
    .els_p   (cmd_els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (cmd_v_i),
    .data_i  (w_cmd_in),
    .ready_o (cmd_ready_o),
    .yumi_i  (w_deq),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // The head stays in the queue until completion, so the outputs hold steady
  // from ISSUE through the dequeue cycle without a separate capture register.
  assign {op_o, addrA_o, addrB_o, addrC_o, addrD_o, scalar_o, w_data_o} = w_head;

  assign w_is_read  = (op_o == OP_READ);
  assign w_res_v    = (r_state == ST_RESULT) & rv_i;
  assign w_yumi     = w_res_v & res_yumi_i;
  assign res_v_o    = w_res_v;
  assign res_data_o = r_data_i;
  assign yumi_o     = w_yumi;
  assign v_o        = r_v;
  assign busy_o     = ~w_empty | (r_state != ST_IDLE);

  // Dequeue on completion only: non-read done in EXEC, or result consumed.
  assign w_deq = ((r_state == ST_EXEC) & done_i & ~w_is_read) | w_yumi;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_ISSUE;
            r_v     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_v && ready_i) begin
            r_state <= ST_EXEC;
            r_v     <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (done_i) r_state <= w_is_read ? ST_RESULT : ST_IDLE;
        end
        ST_RESULT: begin
          if (w_yumi) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_v     <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy is tracked by the queue itself; the full flag is only exported as cmd_ready_o.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Scoreboard bench for vec_cmd_issuer: accepted commands are queued and
// matched against what the DUT presents on each issue handshake.
module tb_vec_cmd_issuer;
  import vec_pkg::*;

  localparam int AW = 3;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_i, cmd_v_i, cmd_ready_o;
  logic [3:0]    cmd_op_i, op_o;
  logic [AW-1:0] cmd_addrA_i, cmd_addrB_i, cmd_addrC_i, cmd_addrD_i;
  logic [AW-1:0] addrA_o, addrB_o, addrC_o, addrD_o;
  logic [7:0]    cmd_scalar_i, scalar_o;
  logic [DW-1:0] cmd_w_data_i, w_data_o, r_data_i, res_data_o;
  logic          v_o, ready_i, done_i, rv_i, yumi_o, res_v_o, res_yumi_i, busy_o;

  int n_vec = 0;
  int n_err = 0;
  vec_cmd_t sb[$];

  always #5 clk = ~clk;

  vec_cmd_issuer dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addrA_i(cmd_addrA_i), .cmd_addrB_i(cmd_addrB_i),
    .cmd_addrC_i(cmd_addrC_i), .cmd_addrD_i(cmd_addrD_i),
    .cmd_scalar_i(cmd_scalar_i), .cmd_w_data_i(cmd_w_data_i),
    .op_o(op_o), .addrA_o(addrA_o), .addrB_o(addrB_o), .addrC_o(addrC_o),
    .addrD_o(addrD_o), .scalar_o(scalar_o), .w_data_o(w_data_o),
    .v_o(v_o), .ready_i(ready_i), .done_i(done_i), .r_data_i(r_data_i),
    .rv_i(rv_i), .yumi_o(yumi_o), .res_v_o(res_v_o), .res_data_o(res_data_o),
    .res_yumi_i(res_yumi_i), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_cmd_t head_out();
    return vec_cmd_t'({op_o, addrA_o, addrB_o, addrC_o, addrD_o, scalar_o, w_data_o});
  endfunction

  function automatic vec_cmd_t cur_in();
    return vec_cmd_t'({cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i, cmd_addrD_i,
                       cmd_scalar_i, cmd_w_data_i});
  endfunction

  // Sample mid-cycle: record accepted enqueues, check each accepted issue.
  always @(negedge clk) begin : mon
    vec_cmd_t e;
    if (!reset_i && cmd_v_i && cmd_ready_o) sb.push_back(cur_in());
    if (!reset_i && v_o && ready_i) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("issue_cmd", head_out(), e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input logic [AW-1:0] c, input logic [AW-1:0] d,
                     input logic [7:0] s, input logic [DW-1:0] w);
    cmd_op_i = op; cmd_addrA_i = a; cmd_addrB_i = b; cmd_addrC_i = c; cmd_addrD_i = d;
    cmd_scalar_i = s; cmd_w_data_i = w; cmd_v_i = 1'b1;
    step();
    cmd_v_i = 1'b0;
  endtask

  // Plays the accelerator for one command; returns with the FSM back in IDLE.
  task automatic do_cmd(input bit is_read, input logic [DW-1:0] rdat);
    int k;
    k = 0;
    while (!v_o && k < 20) begin
      step();
      k++;
    end
    if (!v_o) begin
      chk("issue_timeout", 0, 1);
      return;
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("exec_v_low", v_o, 0);
    done_i = 1'b1;
    if (is_read) begin
      rv_i = 1'b1;
      r_data_i = rdat;
    end
    step();
    done_i = 1'b0;
    if (is_read) begin
      chk("rd_res_v", res_v_o, 1);
      chk("rd_res_data", res_data_o, rdat);
      res_yumi_i = 1'b1;
      #1;
      chk("rd_yumi", yumi_o, 1);
      step();
      res_yumi_i = 1'b0;
      rv_i = 1'b0;
    end
  endtask

  logic [3:0] ops4 [4];
  logic [DW-1:0] rd;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    ops4[0] = OP_SUB; ops4[1] = OP_ADDS; ops4[2] = OP_MULS; ops4[3] = OP_MMUL;
    reset_i = 1'b1; cmd_v_i = 0; cmd_op_i = 0; cmd_addrA_i = 0; cmd_addrB_i = 0;
    cmd_addrC_i = 0; cmd_addrD_i = 0; cmd_scalar_i = 0; cmd_w_data_i = 0;
    ready_i = 0; done_i = 0; rv_i = 0; r_data_i = 0; res_yumi_i = 0;
    repeat (3) step();
    reset_i = 1'b0;
    chk("rst_v", v_o, 0);
    chk("rst_yumi", yumi_o, 0);
    chk("rst_res_v", res_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);

    // Single ADD; rv_i held high to expose any result leakage.
    ready_i = 1'b1; rv_i = 1'b1;
    enq(OP_ADD, 3'd1, 3'd2, 3'd0, 3'd3, 8'h00, 64'h0);
    chk("add_v_after_enq", v_o, 0);
    chk("add_busy_queued", busy_o, 1);
    step();
    chk("add_v_issue", v_o, 1);
    chk("add_res_v_issue", res_v_o, 0);
    step();
    chk("add_v_exec", v_o, 0);
    chk("add_res_v_exec", res_v_o, 0);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("add_busy_done", busy_o, 0);
    chk("add_res_v_done", res_v_o, 0);
    chk("add_yumi_done", yumi_o, 0);
    rv_i = 1'b0;

    // READ with consumer stalling for 3 cycles.
    enq(OP_READ, 3'd5, 3'd0, 3'd0, 3'd0, 8'h00, {$urandom, $urandom});
    step();
    chk("rd_v_issue", v_o, 1);
    step();
    rv_i = 1'b1; r_data_i = 64'hDEADBEEF_01234567; done_i = 1'b1;
    step();
    done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_hold_res_v", res_v_o, 1);
      chk("rd_hold_data", res_data_o, 64'hDEADBEEF_01234567);
      chk("rd_hold_yumi", yumi_o, 0);
      chk("rd_hold_busy", busy_o, 1);
      step();
    end
    res_yumi_i = 1'b1;
    #1;
    chk("rd_yumi_pulse", yumi_o, 1);
    step();
    res_yumi_i = 1'b0;
    chk("rd_yumi_after", yumi_o, 0);
    chk("rd_res_v_idle", res_v_o, 0);
    chk("rd_busy_idle", busy_o, 0);
    rv_i = 1'b0;

    // Fill the queue with the accelerator stalled.
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      enq(ops4[i], AW'(i), AW'(i + 1), AW'(i + 2), AW'(i + 3), 8'($urandom), {$urandom, $urandom});
    chk("full_ready", cmd_ready_o, 0);
    cmd_op_i = OP_WRITE; cmd_w_data_i = 64'hBAD0BAD0BAD0BAD0; cmd_v_i = 1'b1;
    chk("full_ready_5th", cmd_ready_o, 0);
    step();
    cmd_v_i = 1'b0;
    chk("full_ready_after", cmd_ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_v", v_o, 1);
      if (sb.size() != 0) chk("hold_head", head_out(), sb[0]);
      else chk("hold_sb_nonempty", 0, 1);
      step();
    end
    for (int i = 0; i < 4; i++) do_cmd(1'b0, 64'h0);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_busy", busy_o, 0);

    // Back-to-back WRITE then MUL, then more traffic to wrap pointers again.
    enq(OP_WRITE, 3'd7, 3'd0, 3'd0, 3'd6, 8'h5A, {$urandom, $urandom});
    enq(OP_MUL, 3'd2, 3'd4, 3'd0, 3'd1, 8'hA5, {$urandom, $urandom});
    do_cmd(1'b0, 64'h0);
    chk("b2b_idle_v", v_o, 0);
    step();
    chk("b2b_issue_v", v_o, 1);
    do_cmd(1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      enq(ops4[i], AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 8'($urandom),
          {$urandom, $urandom});
      do_cmd(1'b0, 64'h0);
    end
    rd = {$urandom, $urandom};
    enq(OP_READ, 3'd6, 3'd0, 3'd0, 3'd0, 8'h00, 64'h0);
    do_cmd(1'b1, rd);
    chk("wrap_sb_empty", sb.size(), 0);

    // Reset while a command executes with two more queued.
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      enq(ops4[i], AW'(i), 3'd0, 3'd0, 3'd0, 8'h00, {$urandom, $urandom});
    chk("rst_pre_v", v_o, 1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("rst_pre_exec_v", v_o, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    sb.delete();
    chk("midrst_v", v_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", cmd_ready_o, 1);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("midrst_done_busy", busy_o, 0);
    step();
    chk("midrst_done_v", v_o, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
